text_attr_fetch: RTL

//  Text-mode pixel pipeline between VGA timing generator and palette stage. From pixel x/y it

---
 rtl/text_mode_pkg.sv | 26 ++
 rtl/text_blink_timer.sv | 33 +++
 rtl/text_attr_fetch.sv | 134 +++++++++++++
 3 files changed

// File: rtl/text_mode_pkg.sv
// Shared constants for the text-mode pixel pipeline.
// Glyph geometry, attribute bit positions and stage bundles.
package text_mode_pkg;

    localparam int CHAR_W    = 8;
    localparam int CHAR_H    = 16;
    localparam int PIPE_LAT  = 3;

    localparam int FG_LSB    = 0;
    localparam int BG_LSB    = 4;
    localparam int BLINK_BIT = 7;

    typedef struct packed {
        logic       valid;
        logic       cur;
        logic [2:0] px;
        logic [3:0] line;
    } s0_t;

    typedef struct packed {
        logic       valid;
        logic       cur;
        logic [2:0] px;
    } s1_t;

endpackage

// File: rtl/text_blink_timer.sv
// Frame counter producing the blink phase for text and cursor.
// The phase toggles once every BLINK_FRAMES frame ticks.
module text_blink_timer #(
    parameter int BLINK_FRAMES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_frame_tick,
    output logic o_blink_phase
);

    localparam int CW = $clog2(BLINK_FRAMES);

    logic [CW-1:0] r_cnt;
    logic          r_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (i_frame_tick) begin
            if (r_cnt == CW'(BLINK_FRAMES - 1)) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_blink_phase = r_phase;

endmodule

// File: rtl/text_attr_fetch.sv
// Text-mode pixel pipeline: pixel x/y -> char/attr -> glyph -> fg/bg/pix_on.
// Three register stages; syncs travel alongside the pixel data.
module text_attr_fetch
    import text_mode_pkg::*;
#(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 16,
    parameter int CURSOR_START = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        active_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        frame_tick,
    input  logic        blink_en,
    input  logic        cursor_en,
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    output logic [11:0] tram_addr,
    input  logic [15:0] tram_rdata,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_rdata,
    output logic [3:0]  fg,
    output logic [3:0]  bg,
    output logic        pix_on,
    output logic        active_out,
    output logic        hsync_out,
    output logic        vsync_out
);

    logic [6:0] w_col;
    logic [5:0] w_row;
    logic [2:0] w_px;
    logic [3:0] w_line;
    logic       w_cell_ok;
    logic       w_cur;
    logic       w_phase;

    assign w_col  = pix_x[9:3];
    assign w_row  = pix_y[9:4];
    assign w_px   = pix_x[2:0];
    assign w_line = pix_y[3:0];

    // pix_y[9] is kept in the row so rows 32+ never alias onto the screen
    assign w_cell_ok = active_in
                     & (w_col < 7'(COLS))
                     & (w_row < 6'(ROWS));

    assign w_cur = cursor_en
                 & (w_col == cursor_col)
                 & (w_row == {1'b0, cursor_row})
                 & (w_line >= 4'(CURSOR_START));

    assign tram_addr = 12'(w_row[4:0]) * 12'(COLS) + 12'(w_col);

    text_blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_frame_tick  (frame_tick),
        .o_blink_phase (w_phase)
    );

    s0_t                       r_s0;
    s1_t                       r_s1;
    logic [7:0]                r_attr;
    logic [11:0]               r_font_addr;
    logic [PIPE_LAT-1:0][2:0]  r_sync;
    logic [3:0]                r_fg;
    logic [3:0]                r_bg;
    logic                      r_pix_on;

    logic       w_glyph;
    logic       w_hide;
    logic       w_on;
    logic [3:0] w_bg;

    assign w_glyph = font_rdata[3'(CHAR_W - 1) - r_s1.px];
    assign w_bg    = blink_en ? {1'b0, r_attr[BG_LSB +: 3]}
                              : r_attr[BG_LSB +: 4];
    assign w_hide  = blink_en & r_attr[BLINK_BIT] & w_phase;
    assign w_on    = (r_s1.cur & ~w_phase) | (w_glyph & ~w_hide);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0        <= '0;
            r_s1        <= '0;
            r_attr      <= '0;
            r_font_addr <= '0;
            r_sync      <= '0;
            r_fg        <= '0;
            r_bg        <= '0;
            r_pix_on    <= 1'b0;
        end else begin
            r_s0.valid  <= w_cell_ok;
            r_s0.cur    <= w_cur;
            r_s0.px     <= w_px;
            r_s0.line   <= w_line;

            r_s1.valid  <= r_s0.valid;
            r_s1.cur    <= r_s0.cur;
            r_s1.px     <= r_s0.px;
            r_attr      <= tram_rdata[15:8];
            r_font_addr <= {tram_rdata[7:0], r_s0.line};

            r_sync <= {r_sync[PIPE_LAT-2:0],
                       {active_in, hsync_in, vsync_in}};

            if (r_s1.valid) begin
                r_fg     <= r_attr[FG_LSB +: 4];
                r_bg     <= w_bg;
                r_pix_on <= w_on;
            end else begin
                r_fg     <= '0;
                r_bg     <= '0;
                r_pix_on <= 1'b0;
            end
        end
    end

    assign font_addr  = r_font_addr;
    assign fg         = r_fg;
    assign bg         = r_bg;
    assign pix_on     = r_pix_on;
    assign active_out = r_sync[PIPE_LAT-1][2];
    assign hsync_out  = r_sync[PIPE_LAT-1][1];
    assign vsync_out  = r_sync[PIPE_LAT-1][0];

endmodule
